// File: rtl/fetch_pipe_ctrl_if.sv
// Instruction-memory fetch handshake between fetch_pipe_ctrl and imem.
// Only one request is outstanding at a time.
// Request and address stay stable until an ack is seen while the request is high.
interface fetch_pipe_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_ack;
    logic [31:0]     i_imem_rdata;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_ack, i_imem_rdata
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_ack, i_imem_rdata
    );
endinterface

// File: rtl/fetch_pipe_ctrl.sv
// Fetch pipeline controller.
// Owns the PC, the imem fetch handshake, the IF/ID register and the ID/EX valid bit.
// Stalls and flushes come from the hazard unit; branch redirects come from EX.
// A one-entry hold buffer (the HOLD state) keeps a fetched word while IF/ID is stalled.
module fetch_pipe_ctrl #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_pc_stall,
    input  logic                 i_if_id_stall,
    input  logic                 i_id_ex_stall,
    input  logic                 i_if_id_flush,
    input  logic                 i_id_ex_flush,
    input  logic                 i_redirect_valid,
    input  logic [XLEN-1:0]      i_redirect_pc,
    fetch_pipe_ctrl_if.master    imem,
    output logic [XLEN-1:0]      o_pc,
    output logic [XLEN-1:0]      o_if_id_pc,
    output logic [31:0]          o_if_id_instr,
    output logic                 o_if_id_valid,
    output logic                 o_id_ex_valid,
    output logic [CNT_W-1:0]     o_stall_cycles,
    output logic [CNT_W-1:0]     o_flush_events
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DISCARD} state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            req, req_n;
    logic [XLEN-1:0] tgt, tgt_n;        // saved redirect target while discarding
    logic [XLEN-1:0] hold_pc;
    logic [31:0]     hold_instr;
    logic            buf_ld, ld_fetch, ld_hold;

    logic stall, flush, ack_v;
    assign stall = i_pc_stall | i_if_id_stall;
    assign flush = i_if_id_flush;
    // An ack only counts while a request is actually outstanding.
    assign ack_v = req & imem.i_imem_ack;

    // The fetch address is the PC register itself, so it stays put until the PC moves.
    assign o_pc             = pc;
    assign imem.o_imem_addr = pc;
    assign imem.o_imem_req  = req;

    // State register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= BOOT;
        else          state <= state_n;
    end

    // Next state, next PC/request and IF/ID load selects
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        req_n    = req;
        tgt_n    = tgt;
        buf_ld   = 1'b0;
        ld_fetch = 1'b0;
        ld_hold  = 1'b0;
        case (state)
            BOOT: begin
                state_n = FETCH;
                req_n   = 1'b1;
                pc_n    = XLEN'(RESET_PC);
            end
            FETCH: begin
                if (ack_v) begin
                    if (flush) begin
                        // Returned word belongs to the squashed path.
                        if (i_redirect_valid) pc_n = i_redirect_pc;
                        req_n = 1'b1;
                    end else if (stall) begin
                        buf_ld  = 1'b1;
                        req_n   = 1'b0;
                        state_n = HOLD;
                    end else begin
                        ld_fetch = 1'b1;
                        pc_n     = pc + XLEN'(4);
                        req_n    = 1'b1;
                    end
                end else if (flush && i_redirect_valid) begin
                    // The request must complete first; remember where to go afterwards.
                    tgt_n   = i_redirect_pc;
                    state_n = DISCARD;
                end
            end
            HOLD: begin
                if (flush) begin
                    if (i_redirect_valid) pc_n = i_redirect_pc;
                    req_n   = 1'b1;
                    state_n = FETCH;
                end else if (!stall) begin
                    ld_hold = 1'b1;
                    pc_n    = pc + XLEN'(4);
                    req_n   = 1'b1;
                    state_n = FETCH;
                end
            end
            DISCARD: begin
                if (i_redirect_valid) tgt_n = i_redirect_pc;
                if (ack_v) begin
                    pc_n    = i_redirect_valid ? i_redirect_pc : tgt;
                    req_n   = 1'b1;
                    state_n = FETCH;
                end
            end
            default: state_n = BOOT;
        endcase
    end

    // PC, request, redirect target and hold buffer
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc         <= XLEN'(RESET_PC);
            req        <= 1'b0;
            tgt        <= '0;
            hold_pc    <= '0;
            hold_instr <= NOP;
        end else begin
            pc  <= pc_n;
            req <= req_n;
            tgt <= tgt_n;
            if (buf_ld) begin
                hold_pc    <= pc;
                hold_instr <= imem.i_imem_rdata;
            end
        end
    end

    // IF/ID register: flush beats stall, and stall beats load.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_if_id_pc    <= '0;
            o_if_id_instr <= NOP;
            o_if_id_valid <= 1'b0;
        end else if (flush) begin
            o_if_id_instr <= NOP;
            o_if_id_valid <= 1'b0;
        end else if (stall) begin
            o_if_id_valid <= o_if_id_valid;
        end else if (ld_fetch) begin
            o_if_id_pc    <= pc;
            o_if_id_instr <= imem.i_imem_rdata;
            o_if_id_valid <= 1'b1;
        end else if (ld_hold) begin
            o_if_id_pc    <= hold_pc;
            o_if_id_instr <= hold_instr;
            o_if_id_valid <= 1'b1;
        end else begin
            o_if_id_valid <= 1'b0;
        end
    end

    // ID/EX valid bit
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)           o_id_ex_valid <= 1'b0;
        else if (i_id_ex_flush) o_id_ex_valid <= 1'b0;
        else if (!i_id_ex_stall) o_id_ex_valid <= o_if_id_valid;
    end

    // Saturating performance counters
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_stall_cycles <= '0;
            o_flush_events <= '0;
        end else begin
            if (stall && o_stall_cycles != '1) o_stall_cycles <= o_stall_cycles + 1'b1;
            if (flush && o_flush_events != '1) o_flush_events <= o_flush_events + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Directed bench for fetch_pipe_ctrl.
// The imem model answers each address A with the word {16'hA5A5, A[15:0]}.
// Inputs change on the falling edge, and outputs are checked on the falling edge.
module tb_fetch_pipe_ctrl;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, redir;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] pc, if_id_pc;
    logic [31:0] if_id_instr;
    logic if_id_valid, id_ex_valid;
    logic [CNT_W-1:0] stall_cycles, flush_events;
    int n_vec = 0;
    int n_err = 0;

    fetch_pipe_ctrl_if #(.XLEN(XLEN)) imem ();
    assign imem.i_imem_rdata = {16'hA5A5, imem.o_imem_addr[15:0]};

    fetch_pipe_ctrl #(.XLEN(XLEN), .RESET_PC(32'h0), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_pc_stall(pc_stall), .i_if_id_stall(if_id_stall), .i_id_ex_stall(id_ex_stall),
        .i_if_id_flush(if_id_flush), .i_id_ex_flush(id_ex_flush),
        .i_redirect_valid(redir), .i_redirect_pc(redir_pc),
        .imem(imem.master),
        .o_pc(pc), .o_if_id_pc(if_id_pc), .o_if_id_instr(if_id_instr),
        .o_if_id_valid(if_id_valid), .o_id_ex_valid(id_ex_valid),
        .o_stall_cycles(stall_cycles), .o_flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
        n_vec++; if (imem.o_imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want %h", imem.o_imem_addr, 32'h0); end
        n_vec++; if (imem.o_imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", imem.o_imem_req); end
        n_vec++; if (if_id_instr !== 32'h13) begin n_err++; $display("FAIL rst_instr: got %h want %h", if_id_instr, 32'h13); end
        n_vec++; if ({if_id_valid, id_ex_valid} !== 2'b00) begin n_err++; $display("FAIL rst_valid: got %b want 00", {if_id_valid, id_ex_valid}); end
        n_vec++; if (if_id_pc !== 32'h0) begin n_err++; $display("FAIL rst_ifid_pc: got %h want 0", if_id_pc); end
        n_vec++; if ({stall_cycles, flush_events} !== 8'h00) begin n_err++; $display("FAIL rst_cnt: got %h want 00", {stall_cycles, flush_events}); end
    endtask

    task automatic test_stream();
        imem.i_imem_ack = 1'b1;
        rst_n = 1'b1;
        step();
        n_vec++; if ({imem.o_imem_req, imem.o_imem_addr} !== {1'b1, 32'h0}) begin n_err++; $display("FAIL boot_req: got %b/%h want 1/0", imem.o_imem_req, imem.o_imem_addr); end
        n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL boot_valid: got %b want 0", if_id_valid); end
        step();
        n_vec++; if (imem.o_imem_addr !== 32'h4) begin n_err++; $display("FAIL seq_addr4: got %h want 4", imem.o_imem_addr); end
        n_vec++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h0, 32'hA5A5_0000}) begin n_err++; $display("FAIL seq_ifid0: got %b %h %h want 1 0 a5a50000", if_id_valid, if_id_pc, if_id_instr); end
        step();
        n_vec++; if (imem.o_imem_addr !== 32'h8) begin n_err++; $display("FAIL seq_addr8: got %h want 8", imem.o_imem_addr); end
        n_vec++; if ({if_id_valid, if_id_pc} !== {1'b1, 32'h4}) begin n_err++; $display("FAIL seq_ifid4: got %b %h want 1 4", if_id_valid, if_id_pc); end
        n_vec++; if (id_ex_valid !== 1'b1) begin n_err++; $display("FAIL seq_idex: got %b want 1", id_ex_valid); end
    endtask

    task automatic test_wait();
        imem.i_imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if ({imem.o_imem_req, imem.o_imem_addr, if_id_valid} !== {1'b1, 32'h8, 1'b0}) begin n_err++; $display("FAIL wait_hold%0d: got req %b addr %h valid %b want 1 8 0", i, imem.o_imem_req, imem.o_imem_addr, if_id_valid); end
        end
        imem.i_imem_ack = 1'b1;
        step();
        n_vec++; if ({if_id_valid, if_id_pc, imem.o_imem_addr} !== {1'b1, 32'h8, 32'hC}) begin n_err++; $display("FAIL wait_done: got %b %h %h want 1 8 c", if_id_valid, if_id_pc, imem.o_imem_addr); end
    endtask

    task automatic test_stall();
        step();  // word at 0xC enters IF/ID, request for 0x10 issued
        if_id_stall = 1'b1;
        step();
        n_vec++; if ({imem.o_imem_req, pc} !== {1'b0, 32'h10}) begin n_err++; $display("FAIL stall_hold_req: got %b %h want 0 10", imem.o_imem_req, pc); end
        n_vec++; if ({if_id_valid, if_id_pc} !== {1'b1, 32'hC}) begin n_err++; $display("FAIL stall_ifid1: got %b %h want 1 c", if_id_valid, if_id_pc); end
        step();
        n_vec++; if ({imem.o_imem_req, if_id_pc} !== {1'b0, 32'hC}) begin n_err++; $display("FAIL stall_ifid2: got %b %h want 0 c", imem.o_imem_req, if_id_pc); end
        if_id_stall = 1'b0;
        step();
        n_vec++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h10, 32'hA5A5_0010}) begin n_err++; $display("FAIL stall_release: got %b %h %h want 1 10 a5a50010", if_id_valid, if_id_pc, if_id_instr); end
        n_vec++; if ({imem.o_imem_req, imem.o_imem_addr} !== {1'b1, 32'h14}) begin n_err++; $display("FAIL stall_refetch: got %b %h want 1 14", imem.o_imem_req, imem.o_imem_addr); end
        n_vec++; if (stall_cycles !== 4'd2) begin n_err++; $display("FAIL stall_cnt: got %0d want 2", stall_cycles); end
    endtask

    task automatic test_redirect();
        repeat (3) step();  // 0x14, 0x18, 0x1C fetched
        imem.i_imem_ack = 1'b0;
        if_id_flush = 1'b1; redir = 1'b1; redir_pc = 32'h100;
        step();
        if_id_flush = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        n_vec++; if ({imem.o_imem_req, imem.o_imem_addr, if_id_valid} !== {1'b1, 32'h20, 1'b0}) begin n_err++; $display("FAIL redir_pending: got %b %h %b want 1 20 0", imem.o_imem_req, imem.o_imem_addr, if_id_valid); end
        n_vec++; if (flush_events !== 4'd1) begin n_err++; $display("FAIL redir_cnt: got %0d want 1", flush_events); end
        step();
        n_vec++; if ({imem.o_imem_addr, if_id_valid} !== {32'h20, 1'b0}) begin n_err++; $display("FAIL redir_wait: got %h %b want 20 0", imem.o_imem_addr, if_id_valid); end
        imem.i_imem_ack = 1'b1;
        step();
        n_vec++; if ({imem.o_imem_req, imem.o_imem_addr, if_id_valid} !== {1'b1, 32'h100, 1'b0}) begin n_err++; $display("FAIL redir_drop: got %b %h %b want 1 100 0", imem.o_imem_req, imem.o_imem_addr, if_id_valid); end
        step();
        n_vec++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h100, 32'hA5A5_0100}) begin n_err++; $display("FAIL redir_target: got %b %h %h want 1 100 a5a50100", if_id_valid, if_id_pc, if_id_instr); end
        n_vec++; if ({imem.o_imem_addr, flush_events} !== {32'h104, 4'd1}) begin n_err++; $display("FAIL redir_next: got %h %0d want 104 1", imem.o_imem_addr, flush_events); end
    endtask

    task automatic test_flush_stall();
        if_id_flush = 1'b1; if_id_stall = 1'b1; id_ex_flush = 1'b1;
        step();
        if_id_flush = 1'b0; if_id_stall = 1'b0; id_ex_flush = 1'b0;
        n_vec++; if ({if_id_valid, if_id_instr} !== {1'b0, 32'h13}) begin n_err++; $display("FAIL fs_ifid: got %b %h want 0 13", if_id_valid, if_id_instr); end
        n_vec++; if (id_ex_valid !== 1'b0) begin n_err++; $display("FAIL fs_idex: got %b want 0", id_ex_valid); end
        n_vec++; if ({imem.o_imem_addr, flush_events, stall_cycles} !== {32'h104, 4'd2, 4'd3}) begin n_err++; $display("FAIL fs_state: got %h %0d %0d want 104 2 3", imem.o_imem_addr, flush_events, stall_cycles); end
        step();
        n_vec++; if ({if_id_valid, if_id_pc, id_ex_valid} !== {1'b1, 32'h104, 1'b0}) begin n_err++; $display("FAIL fs_refetch: got %b %h %b want 1 104 0", if_id_valid, if_id_pc, id_ex_valid); end
    endtask

    task automatic test_wrap();
        if_id_flush = 1'b1; redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
        step();
        if_id_flush = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        n_vec++; if ({imem.o_imem_addr, if_id_valid} !== {32'hFFFF_FFFC, 1'b0}) begin n_err++; $display("FAIL wrap_redir: got %h %b want fffffffc 0", imem.o_imem_addr, if_id_valid); end
        step();
        n_vec++; if ({imem.o_imem_addr, if_id_pc, if_id_instr} !== {32'h0, 32'hFFFF_FFFC, 32'hA5A5_FFFC}) begin n_err++; $display("FAIL wrap_pc: got %h %h %h want 0 fffffffc a5a5fffc", imem.o_imem_addr, if_id_pc, if_id_instr); end
    endtask

    task automatic test_reset_mid_hold();
        if_id_stall = 1'b1;
        repeat (15) step();
        n_vec++; if ({imem.o_imem_req, if_id_pc} !== {1'b0, 32'hFFFF_FFFC}) begin n_err++; $display("FAIL hold_state: got %b %h want 0 fffffffc", imem.o_imem_req, if_id_pc); end
        n_vec++; if (stall_cycles !== 4'hF) begin n_err++; $display("FAIL stall_sat: got %0d want 15", stall_cycles); end
        rst_n = 1'b0;
        if_id_stall = 1'b0;
        #1;
        n_vec++; if ({pc, imem.o_imem_req, if_id_valid, id_ex_valid} !== {32'h0, 3'b000}) begin n_err++; $display("FAIL mid_rst_ctl: got %h %b%b%b want 0 000", pc, imem.o_imem_req, if_id_valid, id_ex_valid); end
        n_vec++; if ({if_id_pc, if_id_instr, stall_cycles, flush_events} !== {32'h0, 32'h13, 8'h00}) begin n_err++; $display("FAIL mid_rst_data: got %h %h %0d %0d want 0 13 0 0", if_id_pc, if_id_instr, stall_cycles, flush_events); end
        @(negedge clk);
        rst_n = 1'b1;  // ack still high: stale ack seen in BOOT
        step();
        n_vec++; if ({imem.o_imem_req, imem.o_imem_addr, if_id_valid} !== {1'b1, 32'h0, 1'b0}) begin n_err++; $display("FAIL boot_stale: got %b %h %b want 1 0 0", imem.o_imem_req, imem.o_imem_addr, if_id_valid); end
        step();
        n_vec++; if ({if_id_valid, if_id_pc, if_id_instr, imem.o_imem_addr} !== {1'b1, 32'h0, 32'hA5A5_0000, 32'h4}) begin n_err++; $display("FAIL post_rst_fetch: got %b %h %h %h want 1 0 a5a50000 4", if_id_valid, if_id_pc, if_id_instr, imem.o_imem_addr); end
    endtask

    initial begin
        rst_n = 1'b0;
        pc_stall = 1'b0; if_id_stall = 1'b0; id_ex_stall = 1'b0;
        if_id_flush = 1'b0; id_ex_flush = 1'b0; redir = 1'b0; redir_pc = '0;
        imem.i_imem_ack = 1'b0;
        test_reset();
        test_stream();
        test_wait();
        test_stall();
        test_redirect();
        test_flush_stall();
        test_wrap();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
- Consumer of the hazard unit's stall/flush controls.
- Owns the PC register, the instruction-memory fetch handshake, the IF/ID pipeline register and the ID/EX valid bit.
- Applies stalls and flushes cycle-accurately, accepts branch redirects from EX, and keeps a one-entry hold buffer so a fetched instruction is never lost while IF/ID is stalled.
- Sits between instruction memory and the ID stage.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- CNT_W, 16, width of the performance counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_pc_stall  in  1  hold PC.
- i_if_id_stall  in  1  hold IF/ID register.
- i_id_ex_stall  in  1  hold ID/EX valid bit.
- i_if_id_flush  in  1  invalidate IF/ID.
- i_id_ex_flush  in  1  invalidate ID/EX (bubble).
- i_redirect_valid  in  1  branch/jump taken in EX; always coincident with i_if_id_flush.
- i_redirect_pc  in  XLEN  redirect target.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  XLEN  fetch address.
- i_imem_ack  in  1  response valid; data on i_imem_rdata.
- i_imem_rdata  in  32  instruction word.
- o_pc  out  XLEN  PC of the next fetch.
- o_if_id_pc  out  XLEN  PC of the instruction in IF/ID.
- o_if_id_instr  out  32  instruction in IF/ID.
- o_if_id_valid  out  1  IF/ID holds a live instruction.
- o_id_ex_valid  out  1  ID/EX holds a live instruction.
- o_stall_cycles  out  CNT_W  count of cycles with stall = i_pc_stall|i_if_id_stall.
- o_flush_events  out  CNT_W  count of cycles with i_if_id_flush=1.

Behaviour:
- Reset (i_reset=0, asynchronous), all outputs:
  - o_pc = o_imem_addr = RESET_PC.
  - o_imem_req = 0, o_if_id_valid = 0, o_id_ex_valid = 0.
  - o_if_id_pc = 0, o_if_id_instr = 32'h0000_0013 (NOP).
  - Both counters 0, hold buffer empty, state BOOT.
- Imem protocol:
  - Single outstanding request.
  - o_imem_req and o_imem_addr are registered and held stable until i_imem_ack is sampled high.
  - Ack may arrive in the first request cycle or any later cycle.
  - Ack while o_imem_req=0 is ignored.
- Definitions: stall = i_pc_stall | i_if_id_stall; flush = i_if_id_flush.
- State machine, registered:
  - BOOT: next cycle go to FETCH with o_imem_req=1, o_imem_addr=RESET_PC.
  - FETCH, ack=1, no stall, no flush: IF/ID <= {o_imem_addr, rdata}, valid=1. PC += 4. Next request to new PC issued next cycle, req stays 1. Throughput is 1 instr/cycle with zero-wait memory.
  - FETCH, ack=1, stall, no flush: store {addr, rdata} in hold buffer, PC unchanged, req<=0, go to HOLD.
  - FETCH, ack=1, flush: drop rdata. If redirect, PC <= i_redirect_pc. Request new PC next cycle, stay in FETCH.
  - FETCH, ack=0, flush with redirect: record target, go to DISCARD. Request and address stay unchanged.
  - FETCH, ack=0, stall only: keep request pending. Stall does not cancel an in-flight request.
  - HOLD, stall=0, no flush: IF/ID <= hold buffer, valid=1. PC += 4. req<=1 with new PC, go to FETCH.
  - HOLD, flush: empty the buffer, PC <= redirect target, go to FETCH.
  - DISCARD: wait for ack, drop its data, then go to FETCH at the saved target. A second redirect during DISCARD overwrites the saved target.
- IF/ID register priority: flush > stall > load.
  - Flush clears o_if_id_valid to 0 and loads the NOP instruction.
  - Stall holds all IF/ID fields.
  - With no ack and no hold-buffer transfer, o_if_id_valid <= 0 (fetch bubble).
- ID/EX valid priority: i_id_ex_flush -> 0; else i_id_ex_stall -> hold; else o_id_ex_valid <= o_if_id_valid.
- PC arithmetic: +4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0. Redirect targets are taken verbatim, with no alignment check.
- Counters: increment by 1 per qualifying cycle and saturate at all-ones with no wrap.
- Reset mid-request: the outstanding request is abandoned. A stale ack arriving in BOOT is ignored.

Test Plan:
- Reset release, ack tied high -> o_imem_addr sequence 0x0, 0x4, 0x8, and IF/ID shows {0x0, instr0} one cycle after the first ack. o_if_id_valid=1 continuously.
- Ack delayed 3 cycles at addr 0x8 -> addr held at 0x8 for 3 cycles, o_if_id_valid=0 for those cycles, no duplicate fetch.
- if_id_stall=1 for 2 cycles coinciding with ack at 0x10 -> IF/ID holds the previous instruction. The 0x10 word is buffered and enters IF/ID the cycle after stall drops. o_stall_cycles=2.
- Redirect to 0x100 with flush while a request for 0x20 is pending, ack 2 cycles later -> 0x20 data discarded, next request at 0x100, o_if_id_valid=0 until it returns, o_flush_events=1.
- Flush and stall asserted together -> o_if_id_valid=0, instr=0x00000013. With i_id_ex_flush=1, o_id_ex_valid=0 next cycle.
- Assert i_reset=0 mid-HOLD, then release -> all outputs at reset values immediately. Next fetch at RESET_PC; a stale ack during BOOT is ignored.
